// File: rtl/mul4_tourn_pkg.sv
// Shared constants for the 2x2-bit multiplier tournament sequencer:
// FSM encodings, lane/fitness widths, exhaustive operand vectors and golden product.
package mul4_tourn_pkg;

    localparam int LANES = 16;
    localparam int FIT_W = 7;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_DRIVE  = 3'd1;
    localparam state_t S_SAMPLE = 3'd2;
    localparam state_t S_COUNT  = 3'd3;
    localparam state_t S_UPDATE = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    // Lane i carries a = {i[3], i[2]}, b = {i[1], i[0]}.
    localparam logic [LANES-1:0] A1_V = 16'hFF00;
    localparam logic [LANES-1:0] A0_V = 16'hF0F0;
    localparam logic [LANES-1:0] B1_V = 16'hCCCC;
    localparam logic [LANES-1:0] B0_V = 16'hAAAA;

    localparam logic [LANES-1:0] G3 = 16'h8000;
    localparam logic [LANES-1:0] G2 = 16'h4C00;
    localparam logic [LANES-1:0] G1 = 16'h6AC0;
    localparam logic [LANES-1:0] G0 = 16'hA0A0;

endpackage

// File: rtl/mul4_tournament_sched_popcount16.sv
// Combinational population count of one 16-lane match word.
module popcount16 (
    input  logic [15:0] data,
    output logic [4:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'd0, data[i]};
        end
    end

endmodule

// File: rtl/mul4_tournament_sched.sv
// Tournament sequencer: drives exhaustive operands, scores each candidate by
// bit-matches against the golden product and reports the best one.
module mul4_tournament_sched
    import mul4_tourn_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int SETTLE       = 1,
    parameter int PERFECT_STOP = 1,
    localparam int SEL_W       = $clog2(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LANES-1:0] a1,
    output logic [LANES-1:0] a0,
    output logic [LANES-1:0] b1,
    output logic [LANES-1:0] b0,
    output logic [SEL_W-1:0] cand_sel,
    input  logic [LANES-1:0] y3,
    input  logic [LANES-1:0] y2,
    input  logic [LANES-1:0] y1,
    input  logic [LANES-1:0] y0,
    output logic [SEL_W-1:0] winner_idx,
    output logic [FIT_W-1:0] winner_fit
);

    state_t                      state;
    logic [SEL_W-1:0]            k;
    logic [2:0]                  settle_cnt;
    logic [3:0][LANES-1:0]       m;
    logic [1:0]                  word_idx;
    logic [FIT_W-1:0]            acc;
    logic [FIT_W-1:0]            best_fit;
    logic [SEL_W-1:0]            best_idx;

    logic [4:0]                  pc;
    logic                        better;
    logic                        finish;
    logic [FIT_W-1:0]            new_fit;
    logic [SEL_W-1:0]            new_idx;

    assign a1 = A1_V;
    assign a0 = A0_V;
    assign b1 = B1_V;
    assign b0 = B0_V;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    popcount16 u_popcount (
        .data  (m[word_idx]),
        .count (pc)
    );

    // Strict comparison so that ties keep the earlier (lower) index.
    assign better  = (acc > best_fit);
    assign new_fit = better ? acc : best_fit;
    assign new_idx = better ? k : best_idx;
    assign finish  = ((PERFECT_STOP != 0) && (acc == FIT_W'(64)))
                   || (k == SEL_W'(NUM_CAND - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= '0;
            cand_sel   <= '0;
            settle_cnt <= '0;
            m          <= '0;
            word_idx   <= '0;
            acc        <= '0;
            best_fit   <= '0;
            best_idx   <= '0;
            winner_idx <= '0;
            winner_fit <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k          <= '0;
                        cand_sel   <= '0;
                        settle_cnt <= '0;
                        acc        <= '0;
                        best_fit   <= '0;
                        best_idx   <= '0;
                        state      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == 3'(SETTLE - 1)) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 3'd1;
                    end
                end
                S_SAMPLE: begin
                    m[3]     <= ~(y3 ^ G3);
                    m[2]     <= ~(y2 ^ G2);
                    m[1]     <= ~(y1 ^ G1);
                    m[0]     <= ~(y0 ^ G0);
                    word_idx <= '0;
                    state    <= S_COUNT;
                end
                S_COUNT: begin
                    acc      <= acc + FIT_W'(pc);
                    word_idx <= word_idx + 2'd1;
                    if (word_idx == 2'd3) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    best_fit <= new_fit;
                    best_idx <= new_idx;
                    if (finish) begin
                        // Publish here so the winner is valid during the done pulse.
                        winner_fit <= new_fit;
                        winner_idx <= new_idx;
                        state      <= S_DONE;
                    end else begin
                        k          <= k + 1'b1;
                        cand_sel   <= k + 1'b1;
                        acc        <= '0;
                        settle_cnt <= '0;
                        state      <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_tournament_sched.sv
// Directed self-checking bench for mul4_tournament_sched with default parameters.
module tb_mul4_tournament_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] a1, a0, b1, b0;
    logic [1:0]  cand_sel;
    logic [15:0] y3, y2, y1, y0;
    logic [1:0]  winner_idx;
    logic [6:0]  winner_fit;

    int tests;
    int fails;

    localparam logic [15:0] GOLD3 = 16'h8000;
    localparam logic [15:0] GOLD2 = 16'h4C00;
    localparam logic [15:0] GOLD1 = 16'h6AC0;
    localparam logic [15:0] GOLD0 = 16'hA0A0;

    // Candidate bank: cy[candidate][word], muxed by cand_sel.
    logic [15:0] cy [4][4];

    assign y3 = cy[cand_sel][3];
    assign y2 = cy[cand_sel][2];
    assign y1 = cy[cand_sel][1];
    assign y0 = cy[cand_sel][0];

    mul4_tournament_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .a1         (a1),
        .a0         (a0),
        .b1         (b1),
        .b0         (b0),
        .cand_sel   (cand_sel),
        .y3         (y3),
        .y2         (y2),
        .y1         (y1),
        .y0         (y0),
        .winner_idx (winner_idx),
        .winner_fit (winner_fit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_cand(input int c, input logic [15:0] w3, input logic [15:0] w2,
                            input logic [15:0] w1, input logic [15:0] w0);
        cy[c][3] = w3;
        cy[c][2] = w2;
        cy[c][1] = w1;
        cy[c][0] = w0;
    endtask

    // Start a tournament (start sampled at edge 0) and wait for the done pulse.
    task automatic launch(output int done_cyc, output logic [1:0] idx, output logic [6:0] fit,
                          output logic busy1);
        done_cyc = -1;
        idx      = 'x;
        fit      = 'x;
        busy1    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin
                done_cyc = c;
                idx      = winner_idx;
                fit      = winner_fit;
                break;
            end
        end
    endtask

    task automatic load_kwrong();
        for (int c = 0; c < 4; c++) begin
            set_cand(c, GOLD3, GOLD2, GOLD1, GOLD0 ^ 16'((1 << (c + 1)) - 1));
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cand_sel !== 2'd0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b cand_sel=%0d, want 0/0/0", busy, done, cand_sel);
        end
        tests++;
        if (winner_idx !== 2'd0 || winner_fit !== 7'd0) begin
            fails++;
            $display("[TB] FAIL reset_winner: idx=%0d fit=%0d, want 0/0", winner_idx, winner_fit);
        end
        tests++;
        if (a1 !== 16'hFF00 || a0 !== 16'hF0F0 || b1 !== 16'hCCCC || b0 !== 16'hAAAA) begin
            fails++;
            $display("[TB] FAIL operands: %h %h %h %h, want FF00 F0F0 CCCC AAAA", a1, a0, b1, b0);
        end
    endtask

    task automatic test_perfect();
        int d; logic [1:0] i; logic [6:0] f; logic b;
        for (int c = 0; c < 4; c++) set_cand(c, GOLD3, GOLD2, GOLD1, GOLD0);
        launch(d, i, f, b);
        tests++;
        if (b !== 1'b1) begin
            fails++;
            $display("[TB] FAIL perfect_busy: busy=%b in cycle 1, want 1", b);
        end
        tests++;
        if (d != 8) begin
            fails++;
            $display("[TB] FAIL perfect_latency: done cycle %0d, want 8", d);
        end
        tests++;
        if (i !== 2'd0 || f !== 7'd64) begin
            fails++;
            $display("[TB] FAIL perfect_winner: idx=%0d fit=%0d, want 0/64", i, f);
        end
    endtask

    task automatic test_kwrong();
        int d; logic [1:0] i; logic [6:0] f; logic b;
        load_kwrong();
        launch(d, i, f, b);
        tests++;
        if (d != 29) begin
            fails++;
            $display("[TB] FAIL kwrong_latency: done cycle %0d, want 29", d);
        end
        tests++;
        if (i !== 2'd0 || f !== 7'd63) begin
            fails++;
            $display("[TB] FAIL kwrong_winner: idx=%0d fit=%0d, want 0/63", i, f);
        end
    endtask

    task automatic test_inverse();
        int d; logic [1:0] i; logic [6:0] f; logic b;
        for (int c = 0; c < 4; c++) set_cand(c, ~GOLD3, ~GOLD2, ~GOLD1, ~GOLD0);
        launch(d, i, f, b);
        tests++;
        if (d != 29) begin
            fails++;
            $display("[TB] FAIL inverse_latency: done cycle %0d, want 29", d);
        end
        tests++;
        if (i !== 2'd0 || f !== 7'd0) begin
            fails++;
            $display("[TB] FAIL inverse_winner: idx=%0d fit=%0d, want 0/0", i, f);
        end
    endtask

    task automatic test_tie();
        int d; logic [1:0] i; logic [6:0] f; logic b;
        // 24 wrong bits -> 40; 4 wrong bits -> 60.
        set_cand(0, GOLD3, GOLD2, GOLD1 ^ 16'h00FF, ~GOLD0);
        set_cand(1, GOLD3, GOLD2, GOLD1, GOLD0 ^ 16'h000F);
        set_cand(2, GOLD3, GOLD2, GOLD1 ^ 16'h00FF, ~GOLD0);
        set_cand(3, GOLD3 ^ 16'hF000, GOLD2, GOLD1, GOLD0);
        launch(d, i, f, b);
        tests++;
        if (d != 29 || i !== 2'd1 || f !== 7'd60) begin
            fails++;
            $display("[TB] FAIL tie_winner: cycle=%0d idx=%0d fit=%0d, want 29/1/60", d, i, f);
        end
    endtask

    task automatic test_mid_reset();
        int d; logic [1:0] i; logic [6:0] f; logic b;
        int seen;
        seen = 0;
        load_kwrong();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen++;
            if (c == 12) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cand_sel !== 2'd0) begin
            fails++;
            $display("[TB] FAIL midreset_ctrl: busy=%b done=%b cand_sel=%0d, want 0/0/0", busy, done, cand_sel);
        end
        tests++;
        if (winner_fit !== 7'd0 || winner_idx !== 2'd0) begin
            fails++;
            $display("[TB] FAIL midreset_winner: idx=%0d fit=%0d, want 0/0", winner_idx, winner_fit);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("[TB] FAIL midreset_nodone: %0d done pulses, want 0", seen);
        end
        launch(d, i, f, b);
        tests++;
        if (d != 29 || i !== 2'd0 || f !== 7'd63) begin
            fails++;
            $display("[TB] FAIL midreset_rerun: cycle=%0d idx=%0d fit=%0d, want 29/0/63", d, i, f);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, count;
        logic idle_ok;
        first = -1; second = -1; count = 0;
        idle_ok = 1'b0;
        load_kwrong();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin
                count++;
                if (count == 1) first = c;
                else if (count == 2) second = c;
            end
        end
        start = 1'b0;
        tests++;
        if (count != 2 || first != 29 || second != 59) begin
            fails++;
            $display("[TB] FAIL back_to_back: %0d dones at %0d,%0d, want 2 at 29,59", count, first, second);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) begin
                idle_ok = 1'b1;
                break;
            end
        end
        tests++;
        if (idle_ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL back_to_back_idle: busy=%b after timeout, want 0", busy);
        end
    endtask

    task automatic test_restart_ignored();
        int d;
        logic late_busy;
        d = -1;
        late_busy = 1'b0;
        load_kwrong();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 10 || c == 17 || c == 28 || c == 29);
            if (done && d < 0) d = c;
            if (c >= 30 && busy) late_busy = 1'b1;
        end
        start = 1'b0;
        tests++;
        if (d != 29) begin
            fails++;
            $display("[TB] FAIL restart_latency: done cycle %0d, want 29", d);
        end
        tests++;
        if (late_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL restart_not_queued: busy=%b after done, want 0", late_busy);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) set_cand(c, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_perfect();
        test_kwrong();
        test_inverse();
        test_tie();
        test_mid_reset();
        test_back_to_back();
        test_restart_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul4_tournament_sched.md
Name: mul4_tournament_sched

Overview:
- Sequencer that scores NUM_CAND evolved 2x2-bit multiplier candidates and picks the tournament winner.
- Candidates are bit-sliced, LANES=16: one lane per operand pair, 16 lanes give exhaustive coverage.
- The block drives the fixed exhaustive operand vectors and selects one candidate at a time through an external output mux (cand_sel).
- For each candidate it registers y3..y0, counts bit-matches against the golden product, and reports the best index and fitness.
- Sits between the candidate bank and the host/evolution controller.

Parameters:
- NUM_CAND, 4, number of candidates in the tournament (2..16).
- SETTLE, 1, cycles cand_sel is held before y3..y0 is sampled (1..7); covers mux/combinational delay.
- PERFECT_STOP, 1, when 1, evaluation ends as soon as a candidate scores 64.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a tournament; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when the result is valid.
- a1, a0, b1, b0  out  16 each  operand vectors, constant package values.
- cand_sel  out  $clog2(NUM_CAND)  selects the candidate driving y3..y0.
- y3, y2, y1, y0  in  16 each  outputs of the selected candidate.
- winner_idx  out  $clog2(NUM_CAND)  index of the best candidate.
- winner_fit  out  7  fitness of the winner, 0..64.

Behaviour:
- Operand vectors: lane i carries a={i[3],i[2]}, b={i[1],i[0]}.
  - a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA.
- Golden product: G3=16'h8000, G2=16'h4C00, G1=16'h6AC0, G0=16'hA0A0.
- Reset values: busy=0, done=0, cand_sel=0, winner_idx=0, winner_fit=0, state IDLE, all internal registers cleared.
  - Operand outputs are constants and are unaffected by reset.
- Reset mid-tournament: abort immediately. No done pulse; winner outputs are cleared.
- FSM states: IDLE, DRIVE, SAMPLE, COUNT, UPDATE, DONE.
  - IDLE: on start=1, clear k=0, best_fit=0, best_idx=0 -> DRIVE.
  - DRIVE: cand_sel=k, held for SETTLE cycles -> SAMPLE.
  - SAMPLE: register m_j = ~(y_j ^ G_j) for j=0..3 -> COUNT.
  - COUNT: 4 cycles; popcount of one 16-bit word per cycle (m0, m1, m2, m3 in that order) added to a 7-bit accumulator -> UPDATE.
  - UPDATE: if acc > best_fit (strictly greater), best <= (acc, k); ties keep the lower index.
    - If PERFECT_STOP and acc==64 -> DONE.
    - Else if k==NUM_CAND-1 -> DONE.
    - Else k++, clear acc -> DRIVE.
  - DONE: 1 cycle. done=1; winner_idx/winner_fit updated from best in this cycle -> IDLE.
- winner_idx/winner_fit hold their values until the next DONE or rst.
- cand_sel holds its last value in IDLE.
- Latency:
  - Per candidate: SETTLE+6 cycles.
  - If start is sampled at edge 0, done is high in cycle NUM_CAND*(SETTLE+6)+1 (29 with defaults).
- start while busy, or in DONE, is ignored and not queued.
- All-zero fitness: the winner is index 0 with fit 0.

Decomposition:
- Package mul4_tourn_pkg holds:
  - the state enum;
  - LANES=16 and FIT_W=7;
  - the operand constants A1_V, A0_V, B1_V, B0_V;
  - the golden constants G3..G0.
- One sub-module, popcount16: combinational 16-bit -> 5-bit popcount, used by COUNT.

Test Plan:
- All candidates output the golden product (y3..y0 = 8000/4C00/6AC0/A0A0), PERFECT_STOP=1 -> done at cycle 8, winner_idx=0, winner_fit=64.
- Candidate k outputs golden with k+1 wrong bits (k=0..3), defaults -> done at cycle 29, winner_idx=0, winner_fit=63.
- Candidates 1 and 3 both score 60, others 40 -> winner_idx=1, winner_fit=60 (tie keeps the lower index).
- Each candidate outputs the bitwise inverse of golden on all four words -> winner_idx=0, winner_fit=0, done at cycle 29.
- rst asserted at cycle 12 of a run -> next cycle IDLE, busy=0, winner_fit=0, no done pulse. A new start completes normally.
- start held high continuously -> exactly one done per 30-cycle period. Repulsing start during busy has no effect on the timing.
